ex_div: RTL
===========

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width (only 32 is supported).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  EX stage holds a DIV/DIVU/REM/REMU op (decoded from ex_aluop).
REQ-005 SHALL have port signed_div  input  1  1 = DIV/REM, 0 = DIVU/REMU.
REQ-006 SHALL have port op_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-007 SHALL have port dividend  input  WIDTH  ex_reg1 value.
REQ-008 SHALL have port divisor  input  WIDTH  ex_reg2 value.
REQ-009 SHALL have port annul  input  1  flush; abort any in-flight divide.
REQ-010 SHALL have port result  output  WIDTH  selected quotient or remainder, valid while ready=1.
REQ-011 SHALL have port ready  output  1  result valid this cycle.
REQ-012 SHALL have port stall_req  output  1  request to the stall controller to freeze IF..EX.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE, encoded as shared macros.
REQ-014 In IDLE with start=1 and annul=0, SHALL capture operands, signed_div and op_rem at the edge, and move to BUSY with iteration counter 0.
REQ-015 In IDLE with start=1, if divisor==0 or (signed_div and dividend==0x80000000 and divisor==0xFFFFFFFF), SHALL go directly to DONE with the special result latched.
REQ-016 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend.
REQ-017 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-018 BUSY SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes (WIDTH+1-bit partial remainder) and SHALL go to DONE after exactly 32 steps.
REQ-019 For signed ops, SHALL negate the quotient when operand signs differ and negate the remainder when the dividend is negative (remainder sign follows dividend).
REQ-020 Normal latency: ready=1 in the 33rd cycle after the start cycle; special-case latency: ready=1 in the cycle after the start cycle.
REQ-021 In DONE, SHALL assert ready=1 for exactly one cycle with stall_req=0, then return to IDLE.
REQ-022 stall_req SHALL be 1 when (state==IDLE and start=1 and annul=0) or state==BUSY, and 0 otherwise.
REQ-023 annul=1 in any state SHALL force IDLE at the next edge, suppress ready, and drive stall_req=0 combinationally.
REQ-024 A start arriving in the cycle directly after DONE SHALL be treated as a new operation (back-to-back divides).
REQ-025 result SHALL be 0 whenever ready=0.
REQ-026 Operand changes on dividend/divisor during BUSY SHALL NOT affect the result.

Reset
REQ-027 rst=1 at a posedge SHALL set state=IDLE, counter=0, latched operands=0, and force ready=0, result=0 and stall_req=0.
REQ-028 rst mid-BUSY SHALL discard the operation; no ready pulse follows.
REQ-029 rst SHALL take priority over start and annul.

Structure
REQ-030 State encodings, the EXE_DIV/DIVU/REM/REMU aluop codes, and the divide-by-zero and overflow constants SHALL live in the shared defines.v.
REQ-031 SHALL be instantiated inside the EX stage; its stall_req SHALL be ORed into the stall controller's EX request.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 DIVU 100/7 -> after 32 BUSY cycles, ready=1 with result 14; REMU -> 2.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-035 DIVU 5/0 -> ready next cycle with 0xFFFFFFFF; REMU 5/0 -> 5; stall_req=1 only in the start cycle.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0 (1-cycle path).
REQ-037 Start DIVU 1000/3 and assert annul on BUSY cycle 10 -> IDLE next cycle, no ready pulse, stall_req=0.
REQ-038 Assert rst on BUSY cycle 20, then start DIVU 9/3 -> ready after the full latency with result 3 and no stale result.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, divide aluop codes
// and the fixed results returned for divide-by-zero and signed overflow.
package ex_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] EXE_DIV  = 8'h1a;
    localparam logic [7:0] EXE_DIVU = 8'h1b;
    localparam logic [7:0] EXE_REM  = 8'h1c;
    localparam logic [7:0] EXE_REMU = 8'h1d;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUO  = 32'h8000_0000;
    localparam logic [31:0] OVF_REM  = 32'h0000_0000;

    // Lets the EX decoder derive the divider start strobe from ex_aluop.
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV) || (aluop == EXE_DIVU) ||
               (aluop == EXE_REM) || (aluop == EXE_REMU);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// special cases resolved in a single cycle, stalls IF..EX while busy.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             stall_req
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        prem;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        dvs;
    logic [WIDTH-1:0]        res;
    logic                    neg_q, neg_r, op_rem_q;

    logic signed [WIDTH-1:0] dvd_s, dvs_s;
    logic                    dvd_neg, dvs_neg, div_zero, ovf, accept, last;
    logic [WIDTH-1:0]        dvd_mag, dvs_mag;
    logic [WIDTH:0]          shifted, diff;
    logic                    ge;
    logic [WIDTH-1:0]        step_rem, step_quo;

    function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] v);
        return c ? (~v + WIDTH'(1)) : v;
    endfunction

    assign dvd_s    = dividend;
    assign dvs_s    = divisor;
    assign dvd_neg  = signed_div && (dvd_s < 0);
    assign dvs_neg  = signed_div && (dvs_s < 0);
    assign dvd_mag  = neg_if(dvd_neg, dividend);
    assign dvs_mag  = neg_if(dvs_neg, divisor);
    assign div_zero = (divisor == '0);
    assign ovf      = signed_div && (dividend == OVF_QUO) && (divisor == '1);
    assign accept   = (state == IDLE) && start && !annul;
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    // Restoring step: the borrow of the (WIDTH+1)-bit trial subtraction decides the quotient bit.
    assign shifted  = {prem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign ge       = !diff[WIDTH];
    assign step_rem = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo = {quo[WIDTH-2:0], ge};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (div_zero || ovf) ? DONE : BUSY;
            BUSY:    if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            prem     <= '0;
            quo      <= '0;
            dvs      <= '0;
            res      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            op_rem_q <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            prem     <= '0;
            quo      <= dvd_mag;
            dvs      <= dvs_mag;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            op_rem_q <= op_rem;
            if (div_zero)  res <= op_rem ? dividend : DIV0_QUO;
            else if (ovf)  res <= op_rem ? OVF_REM : OVF_QUO;
        end else if (state == BUSY && !annul) begin
            prem <= step_rem;
            quo  <= step_quo;
            cnt  <= cnt + CNT_W'(1);
            // Sign fix-up happens on the final step so DONE only has to present res.
            if (last) res <= op_rem_q ? neg_if(neg_r, step_rem) : neg_if(neg_q, step_quo);
        end
    end

    assign ready     = (state == DONE) && !annul;
    assign result    = ready ? res : '0;
    assign stall_req = !annul && (((state == IDLE) && start) || (state == BUSY));

endmodule
